muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits between the register file and register-file writeback. It consumes the rs1/rs2 read data and produces dataIn, rd and writeRegMem for the register file.
- Multi-cycle with fixed latency. The pipeline holds issue while busy is high.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath constants and the M-extension
// operation/state encodings used by the multiply/divide unit.
package riscv_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, WIDTH iterations for every operation.
module muldiv_unit
   import riscv_pkg::*;
#(
   parameter int unsigned WIDTH      = XLEN,
   parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [WIDTH-1:0]      rs1,
   input  logic [WIDTH-1:0]      rs2,
   input  logic [REG_ADDR_W-1:0] rdIn,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic                  writeRegMem,
   output logic [WIDTH-1:0]      result,
   output logic [REG_ADDR_W-1:0] rdOut
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   muldiv_state_t state, state_next;

   logic [CW-1:0]         count;
   logic [2*WIDTH-1:0]    acc, acc_next;
   logic [WIDTH-1:0]      mag_a, mag_b, raw_a;
   logic [REG_ADDR_W-1:0] rd_q;
   muldiv_op_t            op;
   logic                  neg_main, neg_rem, div_zero, div_ovf;

   logic                  capture, last;
   muldiv_op_t            op_in;
   logic                  sign_a_in, sign_b_in;
   logic [WIDTH-1:0]      ma_in, mb_in;
   logic [WIDTH:0]        mul_sum, rem_sh, diff;
   logic [2*WIDTH-1:0]    prod;
   logic [WIDTH-1:0]      quo, rem, final_res;

   // DONE accepts a new issue so back-to-back ops need no idle cycle
   assign capture = start && !flush && (state == IDLE || state == DONE);
   assign last    = (count == CW'(WIDTH-1));

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (capture) state_next = CALC;
         CALC: if (flush) state_next = IDLE;
               else if (last) state_next = DONE;
         DONE: state_next = capture ? CALC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      done        = (state == DONE);
      writeRegMem = (state == DONE);
   end

   always_comb begin
      op_in     = muldiv_op_t'(funct3);
      sign_a_in = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && rs1[WIDTH-1];
      sign_b_in = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && rs2[WIDTH-1];
      ma_in     = sign_a_in ? -rs1 : rs1;
      mb_in     = sign_b_in ? -rs2 : rs2;
   end

   // Multiply keeps the multiplier in the low half; divide keeps {remainder, quotient}
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
      rem_sh  = acc[2*WIDTH-1:WIDTH-1];
      diff    = rem_sh - {1'b0, mag_b};
      if (op[2]) begin
         if (diff[WIDTH]) acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else             acc_next = {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod      = neg_main ? -acc_next : acc_next;
      quo       = acc_next[WIDTH-1:0];
      rem       = acc_next[2*WIDTH-1:WIDTH];
      final_res = '0;
      unique case (op)
         OP_MUL:                       final_res = prod[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:
            if (div_zero)     final_res = '1;
            else if (div_ovf) final_res = {1'b1, {(WIDTH-1){1'b0}}};
            else              final_res = neg_main ? -quo : quo;
         OP_REM, OP_REMU:
            if (div_zero)     final_res = raw_a;
            else if (div_ovf) final_res = '0;
            else              final_res = neg_rem ? -rem : rem;
         default:              final_res = '0;
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         count    <= '0;
         acc      <= '0;
         mag_a    <= '0;
         mag_b    <= '0;
         raw_a    <= '0;
         rd_q     <= '0;
         op       <= OP_MUL;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
         result   <= '0;
         rdOut    <= '0;
      end else if (capture) begin
         count    <= '0;
         acc      <= funct3[2] ? {{WIDTH{1'b0}}, ma_in} : {{WIDTH{1'b0}}, mb_in};
         mag_a    <= ma_in;
         mag_b    <= mb_in;
         raw_a    <= rs1;
         rd_q     <= rdIn;
         op       <= op_in;
         neg_main <= sign_a_in ^ sign_b_in;
         neg_rem  <= sign_a_in;
         div_zero <= (rs2 == '0);
         div_ovf  <= (op_in inside {OP_DIV, OP_REM}) &&
                     (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
      end else if (state == CALC && !flush) begin
         acc   <= acc_next;
         count <= count + 1'b1;
         if (last) begin
            result <= final_res;
            rdOut  <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, control scenarios
// and random ops checked against an arithmetic reference model.
module tb_muldiv_unit;

   localparam int unsigned W = 32;

   logic          Clock = 1'b0;
   logic          nReset = 1'b0;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [2:0]    funct3 = '0;
   logic [W-1:0]  rs1 = '0;
   logic [W-1:0]  rs2 = '0;
   logic [4:0]    rdIn = '0;
   logic          busy, done, writeRegMem;
   logic [W-1:0]  result;
   logic [4:0]    rdOut;

   muldiv_unit #(.WIDTH(W), .REG_ADDR_W(5)) dut (
      .Clock(Clock), .nReset(nReset), .start(start), .funct3(funct3),
      .rs1(rs1), .rs2(rs2), .rdIn(rdIn), .flush(flush), .busy(busy),
      .done(done), .writeRegMem(writeRegMem), .result(result), .rdOut(rdOut)
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          issue;
   } exp_t;

   exp_t q[$];
   int   done_cycs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = {32'b0, a};
      longint unsigned ub = {32'b0, b};
      longint          p;
      longint unsigned u;
      case (f)
         3'd0: begin p = sa * sb;          return p[31:0];  end
         3'd1: begin p = sa * sb;          return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin u = ua * ub;          return u[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            u = ua / ub; return u[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            u = ua % ub; return u[31:0];
         end
      endcase
   endfunction

   always @(negedge Clock) begin
      if (nReset) begin
         if (writeRegMem !== done) begin
            checks++; errors++;
            $display("FAIL wrm_eq_done: writeRegMem=%b done=%b", writeRegMem, done);
         end
         if (done) begin
            done_cycs.push_back(cyc);
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: result=%h rdOut=%0d at cycle %0d", result, rdOut, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (result !== e.res) begin
                  errors++;
                  $display("FAIL result: got %h expected %h", result, e.res);
               end
               checks++;
               if (rdOut !== e.rd) begin
                  errors++;
                  $display("FAIL rdOut: got %0d expected %0d", rdOut, e.rd);
               end
               checks++;
               if (cyc - e.issue != int'(W)) begin
                  errors++;
                  $display("FAIL latency: got %0d expected %0d", cyc - e.issue, W);
               end
            end
         end
      end
   end

   task automatic wait_slot();
      int n = 0;
      while (busy && !done) begin
         @(negedge Clock);
         n++;
         if (n > 100) begin
            checks++; errors++;
            $display("FAIL wait_slot: busy never released, got busy=%b expected 0", busy);
            break;
         end
      end
   endtask

   task automatic issue(logic [2:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                        bit expect_done, logic [31:0] res);
      @(negedge Clock);
      wait_slot();
      start  = 1'b1;
      funct3 = f;
      rs1    = a;
      rs2    = b;
      rdIn   = rd;
      if (expect_done) q.push_back('{res: res, rd: rd, issue: cyc + 1});
      @(posedge Clock);
      #1;
      start  = 1'b0;
      funct3 = 3'($urandom);
      rs1    = $urandom;
      rs2    = $urandom;
      rdIn   = 5'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      @(negedge Clock);
      while (q.size() != 0 || busy) begin
         @(negedge Clock);
         n++;
         if (n > 2000) begin
            checks++; errors++;
            $display("FAIL drain: pending=%0d busy=%b expected 0 and 0", q.size(), busy);
            q.delete();
            break;
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   logic [2:0]  df [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
   logic [31:0] da [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                           32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
   logic [31:0] db [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                           32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] dr [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                           32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

   initial begin
      #1;
      chk("reset_busy", {31'b0, busy}, 32'h0);
      chk("reset_done", {31'b0, done}, 32'h0);
      chk("reset_wrm", {31'b0, writeRegMem}, 32'h0);
      chk("reset_result", result, 32'h0);
      chk("reset_rdout", {27'b0, rdOut}, 32'h0);
      #22 nReset = 1'b1;

      for (int i = 0; i < 12; i++) issue(df[i], da[i], db[i], 5'(i + 5), 1'b1, dr[i]);
      drain();

      begin
         int s;
         s = done_cycs.size();
         issue(3'd0, 32'd11, 32'd13, 5'd1, 1'b1, 32'd143);
         issue(3'd5, 32'd1000, 32'd9, 5'd2, 1'b1, 32'd111);
         drain();
         if (done_cycs.size() >= s + 2)
            chk("back_to_back", 32'(done_cycs[s+1] - done_cycs[s]), 32'd33);
         else
            chk("back_to_back_count", 32'(done_cycs.size() - s), 32'd2);
      end

      issue(3'd7, 32'd12345, 32'd100, 5'd9, 1'b1, 32'd45);
      repeat (9) @(negedge Clock);
      start = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3; rdIn = 5'd30;
      @(posedge Clock); #1 start = 1'b0;
      drain();

      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 1'b0, '0);
      repeat (19) @(negedge Clock);
      flush = 1'b1;
      @(posedge Clock); #1;
      chk("flush_busy", {31'b0, busy}, 32'h0);
      chk("flush_done", {31'b0, done}, 32'h0);
      flush = 1'b0;
      repeat (40) @(negedge Clock);

      start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2;
      @(posedge Clock); #1;
      chk("flush_start_idle", {31'b0, busy}, 32'h0);
      start = 1'b0; flush = 1'b0;
      repeat (40) @(negedge Clock);

      issue(3'd6, 32'd77, 32'd5, 5'd4, 1'b0, '0);
      repeat (14) @(negedge Clock);
      nReset = 1'b0;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_wrm", {31'b0, writeRegMem}, 32'h0);
      chk("rst_result", result, 32'h0);
      chk("rst_rdout", {27'b0, rdOut}, 32'h0);
      @(negedge Clock) nReset = 1'b1;
      repeat (40) @(negedge Clock);

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  f;
         logic [31:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         issue(f, a, b, 5'($urandom), 1'b1, model(f, a, b));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
